// File: rtl/echo_distance_meter.sv
// Ultrasonic ranging front-end: triggers the sensor, times the echo pulse and
// reports a saturated 5-bit distance with valid / timeout / overrange strobes.
module echo_distance_meter #(
   parameter int TRIG_CYCLES    = 10,
   parameter int TICKS_PER_UNIT = 4,
   parameter int WAIT_TIMEOUT   = 64,
   parameter int PERIOD_CYCLES  = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       echo,
   output logic       trig,
   output logic [4:0] distance,
   output logic       valid,
   output logic       timeout,
   output logic       ovr,
   output logic       busy
);

   // state     | meaning
   // S_IDLE    | waiting for start or period wrap-tick
   // S_TRIG    | driving trig for TRIG_CYCLES cycles
   // S_WAIT    | waiting up to WAIT_TIMEOUT cycles for echo_s
   // S_MEAS    | counting echo-high cycles into distance units
   typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS} state_t;

   localparam int TMAX = (TRIG_CYCLES > WAIT_TIMEOUT) ? TRIG_CYCLES : WAIT_TIMEOUT;
   localparam int CW   = $clog2(TMAX + 1);
   localparam int KW   = $clog2(TICKS_PER_UNIT + 1);
   localparam int PW   = $clog2(PERIOD_CYCLES);

   state_t          state_q, state_d;
   logic [CW-1:0]   timer_q, timer_d;
   logic [KW-1:0]   tick_q, tick_d, tick_b;
   logic [4:0]      unit_q, unit_d, unit_b;
   logic [PW-1:0]   per_q, per_d;
   logic            echo_s1_q, echo_s_q;
   logic            trig_q, trig_d;
   logic [4:0]      distance_q, distance_d;
   logic            valid_q, valid_d;
   logic            timeout_q, timeout_d;
   logic            ovr_q, ovr_d;
   logic            busy_q, busy_d;
   logic            wrap_tick, meas_done, meas_sat, wait_to, count_en;

   assign wrap_tick = (per_q == PW'(PERIOD_CYCLES - 1));
   assign per_d     = wrap_tick ? '0 : per_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         tick_q     <= '0;
         unit_q     <= '0;
         per_q      <= '0;
         echo_s1_q  <= 1'b0;
         echo_s_q   <= 1'b0;
         trig_q     <= 1'b0;
         distance_q <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         tick_q     <= tick_d;
         unit_q     <= unit_d;
         per_q      <= per_d;
         echo_s1_q  <= echo;
         echo_s_q   <= echo_s1_q;
         trig_q     <= trig_d;
         distance_q <= distance_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         ovr_q      <= ovr_d;
         busy_q     <= busy_d;
      end
   end

   // The echo sample that leaves S_WAIT is counted as the first tick, starting from cleared counters.
   assign tick_b   = (state_q == S_MEAS) ? tick_q : '0;
   assign unit_b   = (state_q == S_MEAS) ? unit_q : '0;
   assign count_en = echo_s_q && ((state_q == S_WAIT) || (state_q == S_MEAS));

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      tick_d    = tick_q;
      unit_d    = unit_q;
      meas_done = 1'b0;
      meas_sat  = 1'b0;
      wait_to   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start || wrap_tick) begin
               state_d = S_TRIG;
               timer_d = CW'(TRIG_CYCLES - 1);
            end
         end
         S_TRIG: begin
            if (timer_q == '0) begin
               state_d = S_WAIT;
               timer_d = CW'(WAIT_TIMEOUT - 1);
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_WAIT: begin
            if (echo_s_q) begin
               state_d = S_MEAS;
            end else if (timer_q == '0) begin
               wait_to = 1'b1;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_MEAS: begin
            if (!echo_s_q) begin
               meas_done = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (count_en) begin
         if (tick_b == KW'(TICKS_PER_UNIT - 1)) begin
            tick_d = '0;
            if (unit_b == 5'd31) begin
               meas_sat = 1'b1;
               state_d  = S_IDLE;
            end else begin
               unit_d = unit_b + 1'b1;
            end
         end else begin
            tick_d = tick_b + 1'b1;
            unit_d = unit_b;
         end
      end
   end

   always_comb begin
      trig_d     = (state_d == S_TRIG);
      valid_d    = meas_done | meas_sat;
      ovr_d      = meas_sat;
      timeout_d  = wait_to;
      distance_d = distance_q;
      if (meas_sat) begin
         distance_d = 5'd31;
      end else if (meas_done) begin
         distance_d = unit_q;
      end
      // busy covers the strobe cycle so it falls in the cycle after valid/timeout
      busy_d     = (state_d != S_IDLE) | meas_done | meas_sat | wait_to;
   end

   assign trig     = trig_q;
   assign distance = distance_q;
   assign valid    = valid_q;
   assign timeout  = timeout_q;
   assign ovr      = ovr_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_echo_distance_meter.sv
// Directed + randomized bench for echo_distance_meter; expectations come from
// floor/saturation arithmetic on the echo width and fixed launch timing.
module tb_echo_distance_meter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       echo = 1'b0;
   logic       trig;
   logic [4:0] distance;
   logic       valid, timeout, ovr, busy;

   int n_total = 0;
   int n_pass  = 0;

   localparam int TPU  = 4;
   localparam int TRIG = 10;
   localparam int WTO  = 64;

   echo_distance_meter #(
      .TRIG_CYCLES(TRIG), .TICKS_PER_UNIT(TPU), .WAIT_TIMEOUT(WTO), .PERIOD_CYCLES(256)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig),
      .distance(distance), .valid(valid), .timeout(timeout), .ovr(ovr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset between edges and checks that outputs clear without a clock edge.
   task automatic reset_dut();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_trig", int'(trig), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_distance", int'(distance), 0);
      chk("rst_strobes", int'({valid, timeout, ovr}), 0);
      echo = 1'b0;
      start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Launch via start, wait d cycles after trig falls, then raise echo for h cycles.
   task automatic measure(input int d, input int h, input bit poke, input string tag);
      int w, off_v, nv, nt, stray, dist_v, ovr_v, busy_v, busy_after, lim, exp_off, exp_d, exp_ovr;
      exp_ovr = (h / TPU > 31) ? 1 : 0;
      exp_d   = exp_ovr ? 31 : h / TPU;
      exp_off = exp_ovr ? (2 + 32 * TPU) : (h + 3);
      lim     = ((exp_off > h) ? exp_off : h) + 4;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_trig_rise"}, int'(trig), 1);
      chk({tag, "_busy_rise"}, int'(busy), 1);
      w = 0;
      while (trig === 1'b1 && w < 40) begin
         w++;
         tick();
      end
      chk({tag, "_trig_width"}, w, TRIG);
      repeat (d) tick();
      echo = 1'b1;
      nv = 0; nt = 0; stray = 0; off_v = -1; dist_v = -1; ovr_v = -1; busy_v = -1; busy_after = -1;
      for (int i = 1; i <= lim; i++) begin
         tick();
         echo = (i < h);
         if (poke && i == 5) start = 1'b1;
         if (poke && i == 6) start = 1'b0;
         if (valid === 1'b1) begin
            nv++;
            if (off_v < 0) begin
               off_v = i; dist_v = int'(distance); ovr_v = int'(ovr); busy_v = int'(busy);
            end
         end
         if (off_v > 0 && i == off_v + 1) busy_after = int'(busy);
         if (timeout === 1'b1) nt++;
         if (ovr === 1'b1 && valid !== 1'b1) stray++;
      end
      echo = 1'b0;
      start = 1'b0;
      chk({tag, "_valid_latency"}, off_v, exp_off);
      chk({tag, "_valid_count"}, nv, 1);
      chk({tag, "_distance"}, dist_v, exp_d);
      chk({tag, "_ovr"}, ovr_v, exp_ovr);
      chk({tag, "_no_timeout"}, nt, 0);
      chk({tag, "_stray_ovr"}, stray, 0);
      chk({tag, "_busy_at_strobe"}, busy_v, 1);
      chk({tag, "_busy_after"}, busy_after, 0);
      chk({tag, "_distance_held"}, int'(distance), exp_d);
      chk({tag, "_idle_trig"}, int'(trig), 0);
   endtask

   task automatic no_echo(input int exp_dist);
      int c, nv;
      start = 1'b1;
      tick();
      start = 1'b0;
      c = 0; nv = 0;
      while (timeout !== 1'b1 && c < 150) begin
         tick();
         c++;
         if (valid === 1'b1) nv++;
      end
      chk("timeout_latency", c, TRIG + WTO);
      chk("timeout_no_valid", nv + int'(valid), 0);
      chk("timeout_distance_held", int'(distance), exp_dist);
      tick();
      chk("timeout_width", int'(timeout), 0);
      chk("timeout_busy_after", int'(busy), 0);
   endtask

   initial begin
      int e, d, h;
      // Reset state and first auto-launch at cycle 256
      reset_dut();
      e = 0;
      while (trig !== 1'b1 && e < 300) begin
         tick();
         e++;
      end
      chk("auto_launch_cycle", e, 256);

      // Nominal, floor rounding, then timeout holding the prior distance
      reset_dut();
      tick();
      measure(3, 40, 1'b0, "nominal40");
      measure(5, 3, 1'b0, "floor3");
      measure(0, 43, 1'b0, "floor43");
      no_echo(10);

      // Overrange then a normal measurement with start poked while busy
      reset_dut();
      tick();
      measure(2, 200, 1'b0, "overrange");
      measure(1, 60, 1'b1, "after_ovr");

      // Randomized widths against the floor/saturate model
      for (int k = 0; k < 10; k++) begin
         reset_dut();
         tick();
         d = $urandom_range(0, 20);
         h = $urandom_range(1, 180);
         measure(d, h, (h >= 8), $sformatf("rand%0d_h%0d", k, h));
      end

      // Async reset mid-MEASURE
      reset_dut();
      tick();
      measure(1, 20, 1'b0, "pre_rst");
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (TRIG) tick();
      echo = 1'b1;
      repeat (20) tick();
      chk("mid_meas_busy", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_trig", int'(trig), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_distance", int'(distance), 0);
      echo = 1'b0;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("post_rst_valid", int'(valid), 0);
      chk("post_rst_distance", int'(distance), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/echo_distance_meter.md
# echo_distance_meter

Ultrasonic ranging front-end that produces the 5-bit `distance` word consumed by the `Tarea1` motor/excess/seven-segment stage directly downstream. It issues a trigger pulse to the sensor, then measures the width of the returned echo pulse in clock cycles. It converts that width to distance units and presents a registered, saturated distance with a one-cycle valid strobe. It also reports timeout (no echo) and overrange conditions.

## Interface
- `TRIG_CYCLES`, 10: trigger pulse length in clk cycles (≥1).
- `TICKS_PER_UNIT`, 4: echo-high clk cycles per distance unit (≥1).
- `WAIT_TIMEOUT`, 64: maximum cycles in WAIT_ECHO before abort (≥1).
- `PERIOD_CYCLES`, 256: auto-launch interval; must exceed `TRIG_CYCLES + WAIT_TIMEOUT + 32*TICKS_PER_UNIT + 4`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: launch a measurement now (honoured only in IDLE).
- `echo` in 1: raw sensor echo, asynchronous to clk.
- `trig` out 1: sensor trigger pulse, registered.
- `distance` out 5: last valid measurement, registered, held between updates.
- `valid` out 1: one-cycle strobe, `distance` updated this cycle.
- `timeout` out 1: one-cycle strobe, no echo within `WAIT_TIMEOUT`.
- `ovr` out 1: one-cycle strobe coincident with `valid` when the result saturated.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Reset values:** all outputs 0, FSM in IDLE, period counter 0. Reset asserted mid-operation forces these immediately, without waiting for a clock edge.
- **Echo synchronisation:** `echo` passes through a 2-flop synchronizer to produce `echo_s`, which adds 2 cycles of latency to both edges. Pulse width is therefore preserved.
- **Period counter:** free-running from 0 to `PERIOD_CYCLES-1`, then wraps. Wrap-tick = counter at `PERIOD_CYCLES-1`.
- **IDLE:**
  - `start`=1 or wrap-tick goes to TRIG on the next edge.
  - If both occur in the same cycle, one measurement launches.
  - A wrap-tick or `start` seen outside IDLE is dropped, not queued.
- **TRIG:**
  - `trig`=1 for exactly `TRIG_CYCLES` cycles, then WAIT_ECHO.
  - `echo_s` is ignored during TRIG.
- **WAIT_ECHO:**
  - Wait counter counts cycles.
  - `echo_s`=1 goes to MEASURE, with the tick and unit counters cleared. The first echo-high cycle counts as one tick in MEASURE.
  - A stuck-high echo is measured as a pulse.
  - After `WAIT_TIMEOUT` cycles without `echo_s`=1: pulse `timeout`, go to IDLE. `distance` is unchanged and `valid` stays 0.
- **MEASURE:**
  - Each cycle with `echo_s`=1, the tick counter increments. At `TICKS_PER_UNIT-1` it wraps to 0 and the unit counter increments.
  - `echo_s`=0: `distance` ← unit counter, `valid`=1 for one cycle, go to IDLE. Result = floor(H / `TICKS_PER_UNIT`), where H is the echo-high cycle count.
  - If the unit counter would increment past 31: `distance` ← 31, `valid`=1, `ovr`=1, go to IDLE without waiting for the echo to fall.
  - A remaining echo-high tail is ignored until the next launch.
- **Exclusivity:** `valid` and `timeout` are never high in the same cycle.

## Timing
- **Trigger:** `start` sampled high at edge N in IDLE gives `trig` high from cycle N+1 through N+`TRIG_CYCLES`. WAIT_ECHO is entered at N+`TRIG_CYCLES`+1.
- **Busy:** `busy` rises with `trig` and falls in the cycle after the `valid` or `timeout` strobe.
- **Result latency:** if the raw echo falls at cycle F, `valid` is asserted at F+3 (2-cycle sync plus 1 registered update).
- **Timeout latency:** `timeout` is asserted `WAIT_TIMEOUT` cycles after entering WAIT_ECHO.
- **Strobe width:** strobes are exactly one cycle; `distance` is stable for all other cycles.
- **Back-to-back launches:** the minimum spacing between launches via `start` is one IDLE cycle after the strobe.

## Test plan
- **Reset:** assert `rst` → `trig`, `distance`, `valid`, `timeout`, `ovr`, `busy` all 0. Deassert with `start`=0 → first auto-launch occurs with `trig` rising at cycle 256.
- **Nominal, TPU=4:** `start` pulse, echo high for 40 cycles → `trig` high for 10 cycles, `distance`=5'b01010, `valid` high 1 cycle, `ovr`=0.
- **Floor rounding:** echo high for 43 cycles → `distance`=10. Echo high for 3 cycles → `distance`=0 with `valid`=1.
- **No echo:** → `timeout` pulse 64 cycles after WAIT_ECHO entry, `distance` holds its prior value 10, `valid` never asserted.
- **Overrange:** echo high for 200 cycles → `distance`=31 and `valid`=`ovr`=1 together at echo-high cycle 128. A later `start` produces a normal measurement.
- **Async reset mid-MEASURE:** assert `rst` between clock edges → `trig`, `busy`, `distance` go to 0 before the next edge. `start` while busy (echo active) is ignored, giving exactly one `valid`.
